// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory arbiter.
// Holds the arbiter FSM encoding and the grant identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  localparam logic [3:0] ALL_LANES = 4'hF;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for the arbiter; expire flags when the count reaches TIMEOUT.
// Latency: expire is a decode of the registered count; TIMEOUT=0 never expires.
module arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the I-fetch and D ports, one transaction at a time.
// Grant lands one cycle after request; acks are combinational from MemAck; a DONE cycle follows each access.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit FAIR    = 1'b1,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InstrMemReadEnable,
  input  logic [31:0] PCForInstrMem,
  output logic        InstrMemAck,
  output logic [31:0] Instruction,
  input  logic        DataMemReadEnable,
  input  logic        DataMemWriteEnable,
  input  logic [31:0] DataMemAddress,
  input  logic [31:0] WriteData,
  input  logic [3:0]  DataMemByteEnable,
  output logic        DataMemAck,
  output logic [31:0] ReadDataOriginal,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemReadEnable,
  output logic        MemWriteEnable,
  output logic [3:0]  MemByteEnable,
  input  logic        MemAck,
  input  logic [31:0] MemReadData,
  output logic        BusError
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       ireq, dreq, busy, wd_expire;

  assign ireq = InstrMemReadEnable;
  assign dreq = DataMemReadEnable | DataMemWriteEnable;
  assign busy = (state_q == I_BUSY) || (state_q == D_BUSY);

  // Timer sits at zero outside busy states, so every access starts from a fresh count.
  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (RST),
    .clr    (!busy),
    .en     (busy && !MemAck),
    .expire (wd_expire)
  );

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    MemAddress       = '0;
    MemWriteData     = '0;
    MemReadEnable    = 1'b0;
    MemWriteEnable   = 1'b0;
    MemByteEnable    = '0;
    InstrMemAck      = 1'b0;
    Instruction      = '0;
    DataMemAck       = 1'b0;
    ReadDataOriginal = '0;
    BusError         = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq && ireq) begin
          state_d = (FAIR && (last_grant_q == GNT_D)) ? I_BUSY : D_BUSY;
        end else if (dreq) begin
          state_d = D_BUSY;
        end else if (ireq) begin
          state_d = I_BUSY;
        end
      end
      I_BUSY: begin
        MemAddress    = PCForInstrMem;
        MemReadEnable = 1'b1;
        MemByteEnable = ALL_LANES;
        if (MemAck) begin
          InstrMemAck  = 1'b1;
          Instruction  = MemReadData;
          last_grant_d = GNT_I;
          state_d      = DONE;
        end else if (wd_expire) begin
          BusError = 1'b1;
          state_d  = DONE;
        end
      end
      D_BUSY: begin
        MemAddress     = DataMemAddress;
        MemWriteData   = WriteData;
        MemReadEnable  = DataMemReadEnable;
        MemWriteEnable = DataMemWriteEnable;
        MemByteEnable  = DataMemByteEnable;
        if (MemAck) begin
          DataMemAck       = 1'b1;
          ReadDataOriginal = MemReadData;
          last_grant_d     = GNT_D;
          state_d          = DONE;
        end else if (wd_expire) begin
          BusError = 1'b1;
          state_d  = DONE;
        end
      end
      // One dead cycle lets the requester retire its enable before the next grant decision.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table, fairness sequences and a randomized transaction-level model.
module tb_unified_mem_arbiter;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: FAIR=1, TIMEOUT=5
  logic        rst, i_req, d_re, d_we, m_ack;
  logic [31:0] pc, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        i_ack, d_ack, m_re, m_we, berr;
  logic [31:0] instr, rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  unified_mem_arbiter #(.FAIR(1'b1), .TIMEOUT(5), .TO_W(8)) dut (
    .CLK(clk), .RST(rst),
    .InstrMemReadEnable(i_req), .PCForInstrMem(pc), .InstrMemAck(i_ack), .Instruction(instr),
    .DataMemReadEnable(d_re), .DataMemWriteEnable(d_we), .DataMemAddress(d_addr),
    .WriteData(d_wdata), .DataMemByteEnable(d_be), .DataMemAck(d_ack), .ReadDataOriginal(rdata),
    .MemAddress(m_addr), .MemWriteData(m_wdata), .MemReadEnable(m_re), .MemWriteEnable(m_we),
    .MemByteEnable(m_be), .MemAck(m_ack), .MemReadData(m_rdata), .BusError(berr)
  );

  // Instance B: FAIR=0, watchdog disabled; memory acks immediately when auto_b is set
  logic        i_req_b, d_re_b, auto_b, m_ack_b;
  logic        i_ack_b, d_ack_b, m_re_b, m_we_b, berr_b;
  logic [31:0] instr_b, rdata_b, m_addr_b, m_wdata_b;
  logic [3:0]  m_be_b;

  assign m_ack_b = auto_b & (m_re_b | m_we_b);

  unified_mem_arbiter #(.FAIR(1'b0), .TIMEOUT(0), .TO_W(8)) dut_b (
    .CLK(clk), .RST(rst),
    .InstrMemReadEnable(i_req_b), .PCForInstrMem(32'h0000_0900), .InstrMemAck(i_ack_b), .Instruction(instr_b),
    .DataMemReadEnable(d_re_b), .DataMemWriteEnable(1'b0), .DataMemAddress(32'h0000_0A00),
    .WriteData(32'h0), .DataMemByteEnable(4'hF), .DataMemAck(d_ack_b), .ReadDataOriginal(rdata_b),
    .MemAddress(m_addr_b), .MemWriteData(m_wdata_b), .MemReadEnable(m_re_b), .MemWriteEnable(m_we_b),
    .MemByteEnable(m_be_b), .MemAck(m_ack_b), .MemReadData(32'h0000_BBBB), .BusError(berr_b)
  );

  typedef struct packed {
    logic rst; logic ireq; logic [31:0] pc; logic dre; logic dwe;
    logic [31:0] daddr; logic [31:0] wdata; logic [3:0] be; logic mack; logic [31:0] mrdata;
  } in_t;

  typedef struct packed {
    logic [31:0] maddr; logic [31:0] mwdata; logic mre; logic mwe; logic [3:0] mbe;
    logic iack; logic [31:0] instr; logic dack; logic [31:0] rdata; logic berr;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  out_t dut_o;
  assign dut_o = {m_addr, m_wdata, m_re, m_we, m_be, i_ack, instr, d_ack, rdata, berr};

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t iv(logic r, logic ir, logic [31:0] p, logic dr, logic dw, logic [31:0] a,
                             logic [31:0] wd, logic [3:0] be, logic ma, logic [31:0] md);
    return {r, ir, p, dr, dw, a, wd, be, ma, md};
  endfunction

  function automatic out_t o_idle();
    return '0;
  endfunction

  function automatic out_t o_i(logic [31:0] p, logic ack, logic [31:0] d);
    return {p, 32'h0, Y, N, 4'hF, ack, (ack ? d : 32'h0), N, 32'h0, N};
  endfunction

  function automatic out_t o_d(logic [31:0] a, logic [31:0] wd, logic re, logic we, logic [3:0] be,
                               logic ack, logic [31:0] d, logic be_rr);
    return {a, wd, re, we, be, N, 32'h0, ack, (ack ? d : 32'h0), be_rr};
  endfunction

  task automatic add(input in_t a, input out_t b);
    vec_t v;
    v.i = a;
    v.o = b;
    tbl.push_back(v);
  endtask

  // random-phase model state
  int   busy_side, m_last, lat_cnt, lat_tgt, completed, side, nack;
  logic prev_idle, prev_i, prev_d, ended_prev, exp_start, en, cur_idle, ended_now, e_i, e_d;
  int   busy_cnt, berr_cnt;
  int   r;

  initial begin
    rst = Y; i_req = N; pc = '0; d_re = N; d_we = N; d_addr = '0; d_wdata = '0; d_be = '0;
    m_ack = N; m_rdata = '0; i_req_b = N; d_re_b = N; auto_b = N;

    // reset state
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    // I only, memory acks 3 cycles after enable rises
    add(iv(N, Y, 'h40, N, N, 0, 0, 4'h0, N, 0), o_idle());
    repeat (3) add(iv(N, Y, 'h40, N, N, 0, 0, 4'h0, N, 0), o_i('h40, N, 0));
    add(iv(N, Y, 'h40, N, N, 0, 0, 4'h0, Y, 'h2402_0005), o_i('h40, Y, 'h2402_0005));
    add(iv(N, Y, 'h40, N, N, 0, 0, 4'h0, N, 0), o_idle());
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    // contention with last_grant=I: D write first, then I
    add(iv(N, Y, 'h44, N, Y, 'h100, 'hCAFE_F00D, 4'b0011, N, 0), o_idle());
    add(iv(N, Y, 'h44, N, Y, 'h100, 'hCAFE_F00D, 4'b0011, Y, 'h1111_2222),
        o_d('h100, 'hCAFE_F00D, N, Y, 4'b0011, Y, 'h1111_2222, N));
    add(iv(N, Y, 'h44, N, Y, 'h100, 'hCAFE_F00D, 4'b0011, N, 0), o_idle());
    add(iv(N, Y, 'h44, N, N, 0, 0, 4'h0, N, 0), o_idle());
    add(iv(N, Y, 'h44, N, N, 0, 0, 4'h0, Y, 'h13), o_i('h44, Y, 'h13));
    add(iv(N, Y, 'h44, N, N, 0, 0, 4'h0, N, 0), o_idle());
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    // watchdog expiry on the 6th busy cycle
    add(iv(N, N, 0, Y, N, 'h200, 0, 4'hF, N, 0), o_idle());
    repeat (5) add(iv(N, N, 0, Y, N, 'h200, 0, 4'hF, N, 0), o_d('h200, 0, Y, N, 4'hF, N, 0, N));
    add(iv(N, N, 0, Y, N, 'h200, 0, 4'hF, N, 0), o_d('h200, 0, Y, N, 4'hF, N, 0, Y));
    add(iv(N, N, 0, Y, N, 'h200, 0, 4'hF, N, 0), o_idle());
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    // MemAck on the expiry cycle is a normal completion
    add(iv(N, N, 0, Y, N, 'h300, 0, 4'b1100, N, 0), o_idle());
    repeat (5) add(iv(N, N, 0, Y, N, 'h300, 0, 4'b1100, N, 0), o_d('h300, 0, Y, N, 4'b1100, N, 0, N));
    add(iv(N, N, 0, Y, N, 'h300, 0, 4'b1100, Y, 'hDEAD_BEEF),
        o_d('h300, 0, Y, N, 4'b1100, Y, 'hDEAD_BEEF, N));
    add(iv(N, N, 0, Y, N, 'h300, 0, 4'b1100, N, 0), o_idle());
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    // reset mid-transaction; late MemAck ignored, then regrant
    add(iv(N, Y, 'h80, N, N, 0, 0, 4'h0, N, 0), o_idle());
    add(iv(N, Y, 'h80, N, N, 0, 0, 4'h0, N, 0), o_i('h80, N, 0));
    add(iv(Y, Y, 'h80, N, N, 0, 0, 4'h0, N, 0), o_i('h80, N, 0));
    add(iv(N, Y, 'h80, N, N, 0, 0, 4'h0, Y, 'h99), o_idle());
    add(iv(N, Y, 'h80, N, N, 0, 0, 4'h0, N, 0), o_i('h80, N, 0));
    add(iv(N, Y, 'h80, N, N, 0, 0, 4'h0, Y, 'h77), o_i('h80, Y, 'h77));
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, N, 0), o_idle());
    // stray MemAck in IDLE
    add(iv(N, N, 0, N, N, 0, 0, 4'h0, Y, 'h5555), o_idle());

    repeat (2) @(negedge clk);
    foreach (tbl[k]) begin
      @(negedge clk);
      {rst, i_req, pc, d_re, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata} = tbl[k].i;
      #1;
      chk($sformatf("vec%0d", k), 160'(dut_o), 160'(tbl[k].o));
    end

    // FAIR=1, both held, last_grant=I: D,I,D,I,...
    i_req = Y; pc = 'h500; d_re = N; d_we = Y; d_addr = 'h600; d_wdata = 'hABCD; d_be = 4'hF;
    nack = 0;
    for (int c = 0; c < 40 && nack < 8; c++) begin
      @(negedge clk);
      m_ack = m_re | m_we;
      m_rdata = 32'h1234;
      #1;
      if (i_ack || d_ack) begin
        chk($sformatf("fair_alt%0d", nack), 160'({i_ack, d_ack}), 160'((nack % 2 == 0) ? 2'b01 : 2'b10));
        nack++;
      end
    end
    chk("fair_alt_count", 160'(nack), 160'(8));
    i_req = N; d_we = N;
    @(negedge clk);
    m_ack = N;

    // FAIR=0, both held: D every time
    i_req_b = Y; d_re_b = Y; auto_b = Y;
    nack = 0;
    for (int c = 0; c < 40 && nack < 8; c++) begin
      @(negedge clk);
      #1;
      if (i_ack_b || d_ack_b) begin
        chk($sformatf("nofair%0d", nack), 160'({i_ack_b, d_ack_b}), 160'(2'b01));
        nack++;
      end
    end
    chk("nofair_count", 160'(nack), 160'(8));
    i_req_b = N; d_re_b = N; auto_b = N;
    repeat (3) @(negedge clk);

    // TIMEOUT=0: stays busy past counter wrap with no BusError
    d_re_b = Y;
    busy_cnt = 0; berr_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (m_re_b) busy_cnt++;
      if (berr_b) berr_cnt++;
    end
    chk("wd_off_busy", 160'(busy_cnt), 160'(300));
    chk("wd_off_berr", 160'(berr_cnt), 160'(0));
    @(negedge clk);
    auto_b = Y;
    #1;
    d_re_b = N;
    @(negedge clk);
    auto_b = N;

    // randomized traffic against the transaction-level model
    rst = Y; i_req = N; d_re = N; d_we = N; m_ack = N;
    @(negedge clk);
    rst = N;
    busy_side = -1; m_last = 0; lat_cnt = 0; lat_tgt = 1; completed = 0;
    prev_idle = Y; prev_i = N; prev_d = N; ended_prev = N;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      en = m_re | m_we;
      m_ack = N;
      m_rdata = $urandom;
      if (en) begin
        if (lat_cnt >= lat_tgt) begin
          m_ack = Y; lat_cnt = 0; lat_tgt = $urandom_range(0, 3);
        end else begin
          lat_cnt++;
        end
      end
      #1;
      exp_start = prev_idle && (prev_i || prev_d);
      if (exp_start) begin
        if (prev_i && prev_d) side = (m_last == 0) ? 1 : 0;
        else side = prev_d ? 1 : 0;
        busy_side = side;
      end
      chk("rnd_en", 160'(en), 160'(busy_side >= 0));
      if (busy_side == 0)
        chk("rnd_ibus", 160'({m_addr, m_wdata, m_re, m_we, m_be}), 160'({pc, 32'h0, Y, N, 4'hF}));
      if (busy_side == 1)
        chk("rnd_dbus", 160'({m_addr, m_wdata, m_re, m_we, m_be}), 160'({d_addr, d_wdata, d_re, d_we, d_be}));
      e_i = m_ack && (busy_side == 0);
      e_d = m_ack && (busy_side == 1);
      chk("rnd_ack", 160'({i_ack, instr, d_ack, rdata, berr}),
          160'({e_i, (e_i ? m_rdata : 32'h0), e_d, (e_d ? m_rdata : 32'h0), N}));
      cur_idle  = (busy_side < 0) && !ended_prev;
      ended_now = m_ack && (busy_side >= 0);
      if (ended_now) begin
        m_last = busy_side; busy_side = -1; completed++;
      end
      prev_idle = cur_idle;
      ended_prev = ended_now;
      // requesters: drop on ack, occasionally raise a fresh request
      if (i_ack) i_req = N;
      if (d_ack) begin d_re = N; d_we = N; end
      if (!i_req && !i_ack && $urandom_range(0, 2) == 0) begin
        i_req = Y; pc = $urandom;
      end
      if (!d_re && !d_we && !d_ack && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 7);
        d_re = (r == 0) || (r > 3);
        d_we = (r <= 3);
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end
      prev_i = i_req;
      prev_d = d_re | d_we;
    end
    chk("rnd_progress", 160'(completed >= 100), 160'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
